// File: rtl/dsp_seq_alu_param_if.sv
// Beat-level bus between the pin wrapper and the sequential ALU.
interface dsp_seq_alu_param_if #(
    parameter int BUS_W = 4
);
    logic             enabled;
    logic [BUS_W-1:0] data;
    logic [BUS_W-1:0] result;
    logic [3:0]       flags;
    logic             out_valid;
    logic             out_last;
    logic             busy;

    modport master (output enabled, data,
                    input  result, flags, out_valid, out_last, busy);
    modport slave  (input  enabled, data,
                    output result, flags, out_valid, out_last, busy);
endinterface

// File: rtl/dsp_seq_alu_param.sv
// Serial-beat sequential ALU: opcode, A beats, B beats in; result beats out LS first.
// IDLE: wait opcode | LOAD_A/LOAD_B: collect operand beats | EXEC: compute (MUL = WIDTH cycles) | OUT: stream result
module dsp_seq_alu_param #(
    parameter int WIDTH = 8,
    parameter int BUS_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    dsp_seq_alu_param_if.slave        bus
);
    localparam int BEATS = WIDTH / BUS_W;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int IW    = $clog2(WIDTH);
    localparam int M     = WIDTH - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8,  OP_ROR = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12, OP_CMP = 4'd13, OP_PSB = 4'd14, OP_ACC = 4'd15;

    logic [2:0]         r_state;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_prev, r_res;
    logic [3:0]         r_flags;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_beat, w_shift_in_a, w_shift_in_b;
    logic               w_last_beat, w_exec_done;
    logic [2*WIDTH-1:0] w_mul_term, w_prod_next;
    logic [WIDTH-1:0]   w_x, w_y, w_r, w_fr;
    logic               w_sub, w_c, w_v, w_arith_v;
    logic [WIDTH:0]     w_sum;

    assign w_beat       = WIDTH'(bus.data);
    assign w_shift_in_a = (r_a >> BUS_W) | (w_beat << (WIDTH - BUS_W));
    assign w_shift_in_b = (r_b >> BUS_W) | (w_beat << (WIDTH - BUS_W));
    assign w_last_beat  = (r_cnt == CW'(BEATS - 1));
    assign w_exec_done  = (r_op != OP_MUL) || (r_cnt == CW'(WIDTH - 1));

    // One multiplier bit per EXEC cycle, LSB first.
    assign w_mul_term  = r_b[r_cnt[IW-1:0]] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
    assign w_prod_next = r_prod + w_mul_term;

    always_comb begin
        w_x   = r_a;
        w_y   = r_b;
        w_sub = 1'b0;
        case (r_op)
            OP_SUB, OP_CMP: w_sub = 1'b1;
            OP_INC:         w_y   = WIDTH'(1);
            OP_DEC: begin
                w_y   = WIDTH'(1);
                w_sub = 1'b1;
            end
            OP_ACC: begin
                w_x = r_prev;
                w_y = r_a;
            end
            default: ;
        endcase
    end

    assign w_sum     = w_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
    assign w_arith_v = w_sub ? ((w_x[M] != w_y[M]) && (w_sum[M] != w_x[M]))
                             : ((w_x[M] == w_y[M]) && (w_sum[M] != w_x[M]));

    always_comb begin
        w_r = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ACC, OP_CMP: begin
                w_r = (r_op == OP_CMP) ? r_a : w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = w_arith_v;
            end
            OP_AND: w_r = r_a & r_b;
            OP_OR:  w_r = r_a | r_b;
            OP_XOR: w_r = r_a ^ r_b;
            OP_NOT: w_r = ~r_a;
            OP_SHL: begin w_r = r_a << 1;                    w_c = r_a[M]; end
            OP_SHR: begin w_r = r_a >> 1;                    w_c = r_a[0]; end
            OP_ROL: begin w_r = (r_a << 1) | (r_a >> M);     w_c = r_a[M]; end
            OP_ROR: begin w_r = (r_a >> 1) | (r_a << M);     w_c = r_a[0]; end
            OP_MUL: begin
                w_r = w_prod_next[WIDTH-1:0];
                w_c = |w_prod_next[2*WIDTH-1:WIDTH];
                w_v = |w_prod_next[2*WIDTH-1:WIDTH];
            end
            OP_PSB: w_r = r_b;
            default: ;
        endcase
    end

    // CMP reports Z/N of the difference while passing A through.
    assign w_fr = (r_op == OP_CMP) ? w_sum[WIDTH-1:0] : w_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_prev  <= '0;
            r_res   <= '0;
            r_flags <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.enabled) begin
                    r_op    <= bus.data[3:0];
                    r_cnt   <= '0;
                    r_state <= S_LOAD_A;
                end
                S_LOAD_A: if (bus.enabled) begin
                    r_a <= w_shift_in_a;
                    if (w_last_beat) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD_B;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD_B: if (bus.enabled) begin
                    r_b <= w_shift_in_b;
                    if (w_last_beat) begin
                        r_cnt   <= '0;
                        r_prod  <= '0;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_exec_done) begin
                        r_res   <= w_r;
                        r_flags <= {w_c, (w_fr == '0), w_fr[M], w_v};
                        if (r_op != OP_CMP)
                            r_prev <= w_r;
                        r_cnt   <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_prod <= w_prod_next;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    r_res <= r_res >> BUS_W;
                    if (w_last_beat) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_last  = (r_state == S_OUT) && w_last_beat;
    assign bus.result    = (r_state == S_OUT) ? r_res[BUS_W-1:0] : '0;
    assign bus.flags     = r_flags;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_dsp_seq_alu_param.sv
// Directed bench for dsp_seq_alu_param (WIDTH=8, BUS_W=4) with hand-computed expectations.
module tb_dsp_seq_alu_param;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;

    dsp_seq_alu_param_if #(.BUS_W(4)) bus ();

    dsp_seq_alu_param #(.WIDTH(8), .BUS_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic beat(input logic [3:0] v);
        bus.enabled = 1'b1;
        bus.data    = v;
        @(posedge clk); #1;
        bus.enabled = 1'b0;
        bus.data    = 4'h0;
    endtask

    // Drives one full operation starting in an IDLE cycle; leaves the bench in the following IDLE cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_r, input logic [3:0] exp_f,
                          input int exp_lat, input int stall);
        int c0;
        int k;
        logic [7:0] r;
        c0 = cyc;
        beat(op);
        chk({tag, "_busy_load"}, 32'(bus.busy), 32'd1);
        beat(a[3:0]);
        repeat (stall) begin @(posedge clk); #1; end
        beat(a[7:4]);
        beat(b[3:0]);
        beat(b[7:4]);
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_latency"}, 32'(cyc - c0), 32'(exp_lat));
        chk({tag, "_flags"}, 32'(bus.flags), 32'(exp_f));
        r = exp_r;
        chk({tag, "_beat0"}, 32'(bus.result), 32'(r[3:0]));
        chk({tag, "_last0"}, 32'(bus.out_last), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_beat1"}, 32'(bus.result), 32'(r[7:4]));
        chk({tag, "_last1"}, 32'(bus.out_last), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {bus.busy, bus.out_valid, bus.result}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        bus.enabled = 1'b0;
        bus.data    = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {bus.busy, bus.out_valid, bus.out_last, bus.result, bus.flags}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add",   4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011, 6, 0);
        run_op("sub",   4'd1,  8'h10, 8'h20, 8'hF0, 4'b1010, 6, 0);
        run_op("mul1",  4'd12, 8'h10, 8'h10, 8'h00, 4'b1101, 13, 0);
        run_op("mul2",  4'd12, 8'h0D, 8'h0B, 8'h8F, 4'b0010, 13, 0);
        run_op("and",   4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 6, 0);
        run_op("xor",   4'd4,  8'hA5, 8'h0F, 8'hAA, 4'b0010, 6, 0);
        run_op("or",    4'd3,  8'h50, 8'h0A, 8'h5A, 4'b0000, 6, 0);
        run_op("shl",   4'd6,  8'h81, 8'h00, 8'h02, 4'b1000, 6, 0);
        run_op("shr",   4'd7,  8'h01, 8'h00, 8'h00, 4'b1100, 6, 0);
        run_op("rol",   4'd8,  8'h80, 8'h00, 8'h01, 4'b1000, 6, 0);
        run_op("inc",   4'd10, 8'h7F, 8'h00, 8'h80, 4'b0011, 6, 0);
        run_op("dec",   4'd11, 8'h00, 8'h00, 8'hFF, 4'b1010, 6, 0);
        run_op("passb", 4'd14, 8'h33, 8'h00, 8'h00, 4'b0100, 6, 0);
        run_op("stall", 4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011, 9, 3);

        // Abort an ADD midway through the B operand.
        beat(4'd0);
        beat(4'h3);
        beat(4'h1);
        beat(4'h2);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst", {bus.busy, bus.out_valid, bus.result, bus.flags}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        run_op("acc_clr", 4'd15, 8'h05, 8'h00, 8'h05, 4'b0000, 6, 0);
        run_op("ror",     4'd9,  8'h01, 8'h00, 8'h80, 4'b1010, 6, 0);
        run_op("acc_ovf", 4'd15, 8'h80, 8'h00, 8'h00, 4'b1101, 6, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
